// File: rtl/quadrature_phase_estimator_pkg.sv
// Shared types and the CORDIC arctangent table for the quadrature phase estimator.
// Angles are binary angles: 2^ANGLE_WIDTH corresponds to a full turn.
package quadrature_phase_estimator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  localparam int ATAN_REF_W = 32;

  // atan(2^-i) as a 32-bit binary angle, rounded to angle_width bits (angle_width <= 32).
  function automatic logic [31:0] atan_lut(input int i, input int angle_width);
    logic [31:0] ref_v;
    logic [32:0] rnd;
    int          sh;
    case (i)
      0:       ref_v = 32'h2000_0000;
      1:       ref_v = 32'h12E4_051E;
      2:       ref_v = 32'h09FB_385B;
      3:       ref_v = 32'h0511_11D4;
      4:       ref_v = 32'h028B_0D43;
      5:       ref_v = 32'h0145_D7E1;
      6:       ref_v = 32'h00A2_F61E;
      7:       ref_v = 32'h0051_7C55;
      8:       ref_v = 32'h0028_BE53;
      9:       ref_v = 32'h0014_5F2F;
      10:      ref_v = 32'h000A_2F98;
      11:      ref_v = 32'h0005_17CC;
      12:      ref_v = 32'h0002_8BE6;
      13:      ref_v = 32'h0001_45F3;
      14:      ref_v = 32'h0000_A2FA;
      15:      ref_v = 32'h0000_517D;
      16:      ref_v = 32'h0000_28BE;
      17:      ref_v = 32'h0000_145F;
      18:      ref_v = 32'h0000_0A30;
      19:      ref_v = 32'h0000_0518;
      20:      ref_v = 32'h0000_028C;
      21:      ref_v = 32'h0000_0146;
      22:      ref_v = 32'h0000_00A3;
      23:      ref_v = 32'h0000_0051;
      24:      ref_v = 32'h0000_0029;
      25:      ref_v = 32'h0000_0014;
      26:      ref_v = 32'h0000_000A;
      27:      ref_v = 32'h0000_0005;
      28:      ref_v = 32'h0000_0003;
      29:      ref_v = 32'h0000_0001;
      default: ref_v = 32'h0000_0000;
    endcase
    sh = ATAN_REF_W - angle_width;
    if (sh <= 0) begin
      return ref_v;
    end
    rnd = {1'b0, ref_v} + (33'd1 << (sh - 1));
    return 32'(rnd >> sh);
  endfunction

endpackage

// File: rtl/quadrature_phase_estimator_if.sv
// Sample-in / estimate-out bus of the quadrature phase estimator.
interface quadrature_phase_estimator_if #(
  parameter int DATA_WIDTH  = 7,
  parameter int ANGLE_WIDTH = 16
);

  logic                          sample_clk_ce;
  logic signed [DATA_WIDTH-1:0]  sinewave;
  logic signed [DATA_WIDTH-1:0]  cosinewave;
  logic        [ANGLE_WIDTH-1:0] phase;
  logic        [ANGLE_WIDTH-1:0] phase_increment;
  logic        [DATA_WIDTH+1:0]  magnitude;
  logic                          valid;
  logic                          busy;
  logic                          overrun;

  modport master (
    output sample_clk_ce, sinewave, cosinewave,
    input  phase, phase_increment, magnitude, valid, busy, overrun
  );

  modport slave (
    input  sample_clk_ce, sinewave, cosinewave,
    output phase, phase_increment, magnitude, valid, busy, overrun
  );

endinterface

// File: rtl/quadrature_phase_estimator_cordic_atan_rom.sv
// Combinational arctangent ROM: micro-rotation index -> atan(2^-iter) binary angle.
module cordic_atan_rom
  import quadrature_phase_estimator_pkg::*;
#(
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 12,
  parameter int IW          = $clog2(ITERATIONS)
) (
  input  logic [IW-1:0]          iter,
  output logic [ANGLE_WIDTH-1:0] atan_val
);

  // Table is padded to a power of two so any counter value indexes a defined entry.
  logic [ANGLE_WIDTH-1:0] rom [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_rom
    if (g < ITERATIONS) begin : g_used
      assign rom[g] = ANGLE_WIDTH'(atan_lut(g, ANGLE_WIDTH));
    end else begin : g_pad
      assign rom[g] = '0;
    end
  end

  assign atan_val = rom[iter];

endmodule

// File: rtl/quadrature_phase_estimator.sv
// Iterative CORDIC vectoring: recovers phase, phase step and magnitude from an I/Q sample,
// one micro-rotation per clock.
module quadrature_phase_estimator
  import quadrature_phase_estimator_pkg::*;
#(
  parameter int DATA_WIDTH  = 7,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 12
) (
  input logic                   clk,
  input logic                   arst_n,
  quadrature_phase_estimator_if.slave bus
);

  localparam int XW = DATA_WIDTH + 2;
  localparam int IW = $clog2(ITERATIONS);

  state_t                  state_q, state_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic signed [XW-1:0]    y_q, y_d;
  logic [ANGLE_WIDTH-1:0]  z_q, z_d;
  logic                    zero_q, zero_d;
  logic [ANGLE_WIDTH-1:0]  prev_phase_q, prev_phase_d;
  logic                    first_q, first_d;
  logic [ANGLE_WIDTH-1:0]  phase_q, phase_d;
  logic [ANGLE_WIDTH-1:0]  phase_inc_q, phase_inc_d;
  logic [XW-1:0]           mag_q, mag_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic [ANGLE_WIDTH-1:0]  atan_val;
  logic signed [XW-1:0]    i_ext, q_ext, x_sh, y_sh;
  logic [ANGLE_WIDTH-1:0]  z_out;

  cordic_atan_rom #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ITERATIONS  (ITERATIONS),
    .IW          (IW)
  ) u_atan_rom (
    .iter     (iter_q),
    .atan_val (atan_val)
  );

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    zero_d       = zero_q;
    prev_phase_d = prev_phase_q;
    first_d      = first_q;
    phase_d      = phase_q;
    phase_inc_d  = phase_inc_q;
    mag_d        = mag_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q;

    // Two guard bits let -2^(DATA_WIDTH-1) be negated and absorb the CORDIC gain.
    i_ext = {{2{bus.cosinewave[DATA_WIDTH-1]}}, bus.cosinewave};
    q_ext = {{2{bus.sinewave[DATA_WIDTH-1]}}, bus.sinewave};
    x_sh  = x_q >>> iter_q;
    y_sh  = y_q >>> iter_q;
    z_out = zero_q ? '0 : z_q;

    case (state_q)
      IDLE: begin
        if (bus.sample_clk_ce) begin
          // Left half-plane is folded into the right by a pi pre-rotation.
          if (i_ext < 0) begin
            x_d = -i_ext;
            y_d = -q_ext;
            z_d = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
          end else begin
            x_d = i_ext;
            y_d = q_ext;
            z_d = '0;
          end
          zero_d  = (i_ext == 0) && (q_ext == 0);
          iter_d  = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_val;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_val;
        end
        iter_d = iter_q + 1'b1;
        if (iter_q == IW'(ITERATIONS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        phase_d      = z_out;
        mag_d        = x_q;
        phase_inc_d  = first_q ? '0 : (z_out - prev_phase_q);
        prev_phase_d = z_out;
        first_d      = 1'b0;
        valid_d      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.sample_clk_ce && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      prev_phase_q <= '0;
      first_q      <= 1'b1;
      phase_q      <= '0;
      phase_inc_q  <= '0;
      mag_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
      first_q      <= first_d;
      phase_q      <= phase_d;
      phase_inc_q  <= phase_inc_d;
      mag_q        <= mag_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Rotation datapath: only meaningful while ROTATE, reloaded on every accepted sample.
  always_ff @(posedge clk) begin
    iter_q <= iter_d;
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
    zero_q <= zero_d;
  end

  assign bus.phase           = phase_q;
  assign bus.phase_increment = phase_inc_q;
  assign bus.magnitude       = mag_q;
  assign bus.valid           = valid_q;
  assign bus.busy            = busy_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_quadrature_phase_estimator.sv
// Self-checking bench for quadrature_phase_estimator: fixed vectors, a real-arithmetic
// atan2/sqrt reference for random and sinusoidal inputs, and hand-written control corners.
module tb_quadrature_phase_estimator;

  localparam int DW  = 7;
  localparam int AW  = 16;
  localparam int IT  = 12;
  localparam real PI = 3.14159265358979323846;
  localparam real GAIN = 1.646760258;
  localparam int PH_TOL  = 512;
  localparam int MAG_TOL = 14;
  localparam int LAT     = IT + 1;  // edges after the strobe edge until valid is seen

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  quadrature_phase_estimator_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bus ();

  quadrature_phase_estimator #(
    .DATA_WIDTH  (DW),
    .ANGLE_WIDTH (AW),
    .ITERATIONS  (IT)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  typedef struct {
    int cos_v;
    int sin_v;
    int exp_phase;
    int exp_mag;
  } vec_t;

  task automatic chk_val(input string nm, input int act, input int exp, input int tol);
    n_vec++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) +-%0d", nm, act, act, exp, exp, tol);
    end
  endtask

  task automatic chk_ph(input string nm, input int act, input int exp, input int tol);
    int d;
    d = (act - exp) & 32'hFFFF;
    if (d >= 32768) d -= 65536;
    n_vec++;
    if ((d > tol) || (-d > tol)) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h +-%0d", nm, act, exp, tol);
    end
  endtask

  function automatic int ref_phase(input real i_v, input real q_v);
    real r;
    int  p;
    r = $atan2(q_v, i_v) / (2.0 * PI) * 65536.0;
    if (r < 0.0) r += 65536.0;
    p = int'(r);
    return p & 32'hFFFF;
  endfunction

  function automatic int ref_mag(input real i_v, input real q_v);
    return int'(GAIN * $sqrt(i_v * i_v + q_v * q_v));
  endfunction

  // Strobe one sample, wait (bounded) for valid, then take one more edge to see the pulse end.
  task automatic run_sample(input int c, input int s, output int ph, output int inc,
                            output int mag, output int lat, output int vld_after);
    bus.cosinewave    = DW'(c);
    bus.sinewave      = DW'(s);
    bus.sample_clk_ce = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_ce = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = n;
        break;
      end
    end
    ph  = int'(bus.phase);
    inc = int'(bus.phase_increment);
    mag = int'(bus.magnitude);
    @(posedge clk);
    #1;
    vld_after = int'(bus.valid);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    int ph, inc, mag, lat, va;
    int c, s, p, cnt;
    real ang;

    vecs[0] = '{63,   0, 'h0000, 104};
    vecs[1] = '{0,   63, 'h4000, 104};
    vecs[2] = '{-63,  0, 'h8000, 104};
    vecs[3] = '{0,  -63, 'hC000, 104};
    vecs[4] = '{-64, -64, 'hA000, 149};
    vecs[5] = '{63,  63, 'h2000, 147};
    vecs[6] = '{-64, 63, 'h6000, 148};

    bus.sample_clk_ce = 1'b0;
    bus.cosinewave    = '0;
    bus.sinewave      = '0;

    // Reset state
    #2;
    chk_val("reset phase", int'(bus.phase), 0, 0);
    chk_val("reset phase_increment", int'(bus.phase_increment), 0, 0);
    chk_val("reset magnitude", int'(bus.magnitude), 0, 0);
    chk_val("reset valid", int'(bus.valid), 0, 0);
    chk_val("reset busy", int'(bus.busy), 0, 0);
    chk_val("reset overrun", int'(bus.overrun), 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed vectors
    for (int k = 0; k < 7; k++) begin
      run_sample(vecs[k].cos_v, vecs[k].sin_v, ph, inc, mag, lat, va);
      chk_val($sformatf("vec%0d latency", k), lat, LAT, 0);
      chk_val($sformatf("vec%0d valid pulse width", k), va, 0, 0);
      chk_ph($sformatf("vec%0d phase", k), ph, vecs[k].exp_phase, PH_TOL);
      chk_val($sformatf("vec%0d magnitude", k), mag, vecs[k].exp_mag, MAG_TOL);
      if (k == 0) chk_val("vec0 first phase_increment", inc, 0, 0);
      else chk_ph($sformatf("vec%0d phase_increment", k), inc,
                  (vecs[k].exp_phase - vecs[k-1].exp_phase) & 32'hFFFF, 2 * PH_TOL);
    end

    // Random near-full-scale vectors against the real-valued reference
    for (int k = 0; k < 30; k++) begin
      c = 63;
      s = 0;
      for (int t = 0; t < 200; t++) begin
        c = int'($urandom_range(127)) - 64;
        s = int'($urandom_range(127)) - 64;
        if (c * c + s * s >= 56 * 56) break;
      end
      run_sample(c, s, ph, inc, mag, lat, va);
      chk_val($sformatf("rand%0d latency", k), lat, LAT, 0);
      chk_ph($sformatf("rand%0d phase (%0d,%0d)", k, c, s), ph, ref_phase(real'(c), real'(s)), PH_TOL);
      chk_val($sformatf("rand%0d magnitude (%0d,%0d)", k, c, s), mag, ref_mag(real'(c), real'(s)), MAG_TOL);
    end

    // Sinusoidal input, step 0x0400 per sample, crossing the phase wrap
    do_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 70; k++) begin
      p   = ('h0123 + k * 'h0400) & 32'hFFFF;
      ang = real'(p) * 2.0 * PI / 65536.0;
      c   = int'(63.0 * $cos(ang));
      s   = int'(63.0 * $sin(ang));
      run_sample(c, s, ph, inc, mag, lat, va);
      chk_ph($sformatf("sine%0d phase", k), ph, p, PH_TOL);
      if (k == 0) chk_val("sine0 phase_increment", inc, 0, 0);
      else chk_ph($sformatf("sine%0d phase_increment", k), inc, 'h0400, PH_TOL);
      @(posedge clk);
      #1;
    end

    // Second strobe 3 clocks after the first is dropped and flagged
    chk_val("overrun before", int'(bus.overrun), 0, 0);
    bus.cosinewave    = DW'(63);
    bus.sinewave      = DW'(0);
    bus.sample_clk_ce = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.cosinewave    = DW'(0);
    bus.sinewave      = DW'(63);
    bus.sample_clk_ce = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_ce = 1'b0;
    chk_val("overrun set", int'(bus.overrun), 1, 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = n;
        break;
      end
    end
    chk_val("overrun first result latency", lat, LAT - 3, 0);
    chk_ph("overrun first result phase", int'(bus.phase), 'h0000, PH_TOL);
    chk_val("overrun first result magnitude", int'(bus.magnitude), 104, MAG_TOL);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid) cnt++;
    end
    chk_val("dropped strobe produced no result", cnt, 0, 0);
    chk_val("overrun held", int'(bus.overrun), 1, 0);

    // Reset asserted mid-rotation (iter=5) aborts at once
    bus.cosinewave    = DW'(63);
    bus.sinewave      = DW'(63);
    bus.sample_clk_ce = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_clk_ce = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_val("busy before abort", int'(bus.busy), 1, 0);
    arst_n = 1'b0;
    #1;
    chk_val("abort phase", int'(bus.phase), 0, 0);
    chk_val("abort phase_increment", int'(bus.phase_increment), 0, 0);
    chk_val("abort magnitude", int'(bus.magnitude), 0, 0);
    chk_val("abort valid", int'(bus.valid), 0, 0);
    chk_val("abort busy", int'(bus.busy), 0, 0);
    chk_val("abort overrun", int'(bus.overrun), 0, 0);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid) cnt++;
    end
    chk_val("aborted sample produced no result", cnt, 0, 0);
    run_sample(0, 63, ph, inc, mag, lat, va);
    chk_val("post-abort latency", lat, LAT, 0);
    chk_ph("post-abort phase", ph, 'h4000, PH_TOL);
    chk_val("post-abort phase_increment", inc, 0, 0);

    // All-zero sample is reported exactly as phase 0, magnitude 0
    run_sample(0, 0, ph, inc, mag, lat, va);
    chk_val("zero latency", lat, LAT, 0);
    chk_val("zero phase", ph, 0, 0);
    chk_val("zero magnitude", mag, 0, 0);
    chk_ph("zero phase_increment", inc, 'hC000, 0 + PH_TOL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
